// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and defaults for the clock-division controller.
// Holds the FSM state encoding and the default widths / terminal count.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DIV_W_DEF   = 8;
  localparam int C2_MAX_DEF  = 3;
  localparam int C2_SIZE_DEF = 2;

endpackage

// File: rtl/half_period_timer.sv
// half_period_timer: counts half periods of div_q+1 cycles and toggles clk_div.
// Ports: clk, reset (async low), run, div_q in; clk_div, tick, rise, fall out.
module half_period_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div_q,
  output logic             clk_div,
  output logic             tick,
  output logic             rise,
  output logic             fall
);

  logic [DIV_W-1:0] hcnt;
  logic             wrap;

  // rise/fall mark the cycle whose closing edge toggles clk_div
  assign wrap = run && (hcnt == div_q);
  assign rise = wrap && !clk_div;
  assign fall = wrap && clk_div;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt    <= '0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
    end else if (!run) begin
      hcnt    <= '0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= rise;
      if (wrap) begin
        hcnt    <= '0;
        clk_div <= ~clk_div;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: start/stop sequencing of the divided enable and en_d.
// Ports: clk, reset, div_val, load, start, stop in; clk_div, en_d, tick,
// shadow_cnt, busy, done out (all registered).
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int C2_MAX  = C2_MAX_DEF,
  parameter int C2_SIZE = C2_SIZE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIV_W-1:0]   div_val,
  input  logic               load,
  input  logic               start,
  input  logic               stop,
  output logic               clk_div,
  output logic               en_d,
  output logic               tick,
  output logic [C2_SIZE-1:0] shadow_cnt,
  output logic               busy,
  output logic               done
);

  localparam logic [C2_SIZE-1:0] CMAX = C2_SIZE'(C2_MAX);
  localparam logic [C2_SIZE-1:0] ONE  = C2_SIZE'(1);

  state_t             state, state_d;
  logic [DIV_W-1:0]   div_q, div_q_d;
  logic [C2_SIZE-1:0] shadow_d;
  logic               en_d_d, busy_d, done_d;
  logic               seen, seen_d;
  logic               rise, fall;

  half_period_timer #(
    .DIV_W(DIV_W)
  ) u_tmr (
    .clk     (clk),
    .reset   (reset),
    .run     (busy),
    .div_q   (div_q),
    .clk_div (clk_div),
    .tick    (tick),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      div_q      <= '0;
      en_d       <= 1'b0;
      shadow_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      seen       <= 1'b0;
    end else begin
      state      <= state_d;
      div_q      <= div_q_d;
      en_d       <= en_d_d;
      shadow_cnt <= shadow_d;
      busy       <= busy_d;
      done       <= done_d;
      seen       <= seen_d;
    end
  end

  always_comb begin
    state_d  = state;
    div_q_d  = div_q;
    en_d_d   = en_d;
    done_d   = 1'b0;
    seen_d   = seen;
    shadow_d = shadow_cnt;

    // mirror of the downstream counter, clocked by each clk_div rise
    if (rise) begin
      if (shadow_cnt == CMAX) shadow_d = ONE;
      else if (en_d)          shadow_d = shadow_cnt + 1'b1;
      else                    shadow_d = '0;
    end

    unique case (state)
      IDLE: begin
        if (load) div_q_d = div_val;
        if (start) begin
          state_d = RUN;
          en_d_d  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
          en_d_d  = 1'b0;
          seen_d  = 1'b0;
        end
      end
      DRAIN: begin
        // one rise with en_d low clears downstream, then end on next fall
        if (rise) seen_d = 1'b1;
        if (seen && fall) begin
          state_d = IDLE;
          done_d  = 1'b1;
          seen_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed + randomized bench for clk_div_ctrl.
// Reference model derives clk_div from elapsed run cycles arithmetically.
module tb_clk_div_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] div_val = '0;
  logic          clk_div, en_d, tick, busy, done;
  logic [1:0]    shadow_cnt;

  int compared = 0;
  int mismatched = 0;

  int m_mode, m_d, m_t, m_sh;
  bit m_en, m_ck, m_tick, m_done, m_drained;

  clk_div_ctrl #(
    .DIV_W   (DW),
    .C2_MAX  (3),
    .C2_SIZE (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .div_val    (div_val),
    .load       (load),
    .start      (start),
    .stop       (stop),
    .clk_div    (clk_div),
    .en_d       (en_d),
    .tick       (tick),
    .shadow_cnt (shadow_cnt),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // level of clk_div t cycles after the run began
  function automatic bit ck_at(int t, int d);
    return ((t / (d + 1)) % 2) == 1;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_d = 0; m_t = 0; m_sh = 0;
    m_en = 0; m_ck = 0; m_tick = 0; m_done = 0; m_drained = 0;
  endtask

  task automatic m_step(bit ld, bit st, bit sp, int dv);
    bit nck, rs, fl;
    m_done = 0;
    m_tick = 0;
    if (m_mode == 0) begin
      if (ld) m_d = dv;
      if (st) begin
        m_mode = 1; m_t = 0; m_en = 1;
      end
    end else begin
      nck = ck_at(m_t + 1, m_d);
      rs = nck && !m_ck;
      fl = !nck && m_ck;
      m_t++;
      m_ck = nck;
      if (rs) begin
        m_tick = 1;
        if (m_sh == 3) m_sh = 1;
        else if (m_en) m_sh = m_sh + 1;
        else m_sh = 0;
        if (m_mode == 2) m_drained = 1;
      end
      if (m_mode == 2 && m_drained && fl) begin
        m_mode = 0; m_done = 1; m_drained = 0;
      end else if (m_mode == 1 && sp) begin
        m_mode = 2; m_en = 0; m_drained = 0;
      end
    end
  endtask

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("clk_div", {7'b0, clk_div}, {7'b0, m_ck});
    chk("tick", {7'b0, tick}, {7'b0, m_tick});
    chk("en_d", {7'b0, en_d}, {7'b0, m_en});
    chk("shadow_cnt", {6'b0, shadow_cnt}, 8'(m_sh));
    chk("busy", {7'b0, busy}, {7'b0, (m_mode != 0)});
    chk("done", {7'b0, done}, {7'b0, m_done});
  endtask

  task automatic cyc(bit ld, bit st, bit sp, int dv);
    load = ld; start = st; stop = sp; div_val = DW'(dv);
    @(posedge clk);
    m_step(ld, st, sp, dv);
    @(negedge clk);
    check_all();
    load = 0; start = 0; stop = 0;
  endtask

  task automatic rnd_cyc(bit allow_stop);
    cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
        allow_stop ? bit'($urandom_range(0, 1)) : 1'b0,
        int'($urandom_range(0, 255)));
  endtask

  task automatic run_until_done(int bound, bit junk);
    bit got;
    got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      if (junk) rnd_cyc(1'b1);
      else cyc(0, 0, 0, 0);
      if (m_done) got = 1;
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: no done within %0d cycles", bound);
    end
  endtask

  task automatic run_until(int bound, int sh, bit need_ck, bit need_tick);
    bit got;
    got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      cyc(0, 0, 0, 0);
      if (m_sh == sh && (!need_ck || m_ck) && (!need_tick || m_tick)) got = 1;
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL wait_timeout: shadow %0d not reached in %0d", sh, bound);
    end
  endtask

  initial begin
    m_reset();
    #2;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 0, 0);

    // div 3: period 8, shadow 1,2,3,1,2,3
    cyc(1, 0, 0, 3);
    cyc(0, 1, 0, 0);
    repeat (48) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    run_until_done(40, 0);
    repeat (2) cyc(0, 0, 0, 0);

    // load and start together, div 0
    cyc(1, 1, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    run_until_done(10, 0);

    // div 1, stop on the tick that brings shadow to 2
    cyc(1, 1, 0, 1);
    run_until(20, 2, 0, 1);
    cyc(0, 0, 1, 0);
    run_until_done(20, 0);
    cyc(0, 0, 0, 0);

    // div 2, stop on the tick that brings shadow to 3
    cyc(1, 1, 0, 2);
    run_until(40, 3, 0, 1);
    cyc(0, 0, 1, 0);
    run_until_done(40, 0);
    cyc(0, 0, 0, 0);

    // ignored load/start in RUN and DRAIN, restart with old divisor
    cyc(1, 0, 0, 4);
    cyc(0, 1, 0, 0);
    repeat (6) cyc(1, 1, 0, 5);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 40 && m_mode != 0; i++) cyc(1, 1, 1, 5);
    chk("drain_end_busy", {7'b0, busy}, 8'd0);
    cyc(0, 1, 0, 0);
    repeat (20) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    run_until_done(40, 0);

    // async reset while clk_div high and shadow 2
    cyc(1, 1, 0, 1);
    run_until(40, 2, 1, 0);
    #1 reset = 1'b0;
    #1 m_reset();
    check_all();
    @(negedge clk);
    check_all();
    reset = 1'b1;
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    run_until_done(10, 0);

    // randomized runs
    for (int k = 0; k < 25; k++) begin
      int d;
      int n;
      d = int'($urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) cyc(0, 0, 0, 0);
      if ($urandom_range(0, 1) == 1) begin
        cyc(1, 1, 0, d);
      end else begin
        cyc(1, 0, 0, d);
        cyc(0, 1, 0, 0);
      end
      n = int'($urandom_range(0, 40));
      for (int i = 0; i < n; i++) rnd_cyc(1'b0);
      cyc(0, 0, 1, 0);
      run_until_done(60, 1);
    end

    // widest divisor
    cyc(1, 1, 0, 255);
    repeat (520) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    run_until_done(1100, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Sequencing controller for the clock-division datapath. Generates the divided enable waveform (clk_div) from a programmable divisor and drives en_d for the downstream 2-bit period counter. Handles start/stop, so the downstream counter always starts and ends from a clean state. Keeps a shadow copy of the downstream count and reports completion.

Parameters:
DIV_W, 8, width of divisor register / half-period counter
C2_MAX, 3, terminal value of downstream period counter (wraps to 1)
C2_SIZE, 2, width of downstream period counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
div_val  input  DIV_W  half-period length minus one; sampled on load
load  input  1  capture div_val into div_q (IDLE only; ignored elsewhere)
start  input  1  begin generation (IDLE only)
stop  input  1  request orderly stop (RUN only)
clk_div  output  1  divided enable waveform, drives downstream enable
en_d  output  1  count-enable to downstream counter
tick  output  1  one-cycle pulse coincident with each 0->1 of clk_div
shadow_cnt  output  C2_SIZE  mirror of downstream counter value
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse on DRAIN->IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, div_q=0, hcnt=0, clk_div=0, en_d=0, tick=0, shadow_cnt=0, busy=0, done=0. Reset mid-run aborts immediately; no done pulse.
- All outputs are registered.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - load=1 -> div_q<=div_val next cycle.
  - start=1 -> RUN next cycle, with hcnt=0, clk_div=0, en_d=1.
  - load and start in the same cycle: start uses the newly loaded div_val, i.e. the datapath uses the div_val value directly.
- Half-period timer (RUN and DRAIN):
  - hcnt increments each cycle.
  - When hcnt==div_q: hcnt<=0 and clk_div toggles.
  - Full clk_div period = 2*(div_q+1) cycles. div_q=0 gives a toggle every cycle (period 2). div_q=2^DIV_W-1 is legal, with no overflow.
- tick: asserted in the same cycle clk_div becomes 1.
- shadow_cnt updates on each tick, using the downstream rule:
  - if shadow_cnt==C2_MAX -> 1
  - else if en_d -> shadow_cnt+1
  - else -> 0
  - en_d is the value registered before the tick cycle.
- RUN:
  - stop=1 -> DRAIN next cycle, with en_d<=0.
  - stop in the same cycle as a clk_div toggle: the toggle still happens.
  - start and load are ignored.
- DRAIN:
  - en_d=0. Toggling continues until exactly one more rising edge of clk_div has been issued, so the downstream counter clears to 0 (unless it sits at C2_MAX, where it wraps to 1; shadow_cnt mirrors this).
  - Toggling then continues to the following falling toggle.
  - In the cycle clk_div returns to 0: state<=IDLE, done=1 for one cycle, hcnt<=0.
  - stop and start are ignored in DRAIN.
- stop arriving while clk_div=1 in RUN: the current high half completes, one full low+high period follows, then a final low toggle ends DRAIN.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Package clk_div_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2)
  - default DIV_W / C2_MAX / C2_SIZE constants
- Sub-module half_period_timer:
  - contains hcnt, div_q compare, clk_div toggle and tick generation
  - inputs: run, div_q; outputs: clk_div, tick, fall (one-cycle pulse on 1->0)
- The top level holds the FSM, en_d and shadow_cnt.

Test Plan:
- Reset with reset=0 mid-RUN (clk_div=1, shadow_cnt=2) -> all outputs 0 in the same cycle; state IDLE after release; no done.
- load div_val=3, then start -> clk_div period 8 cycles (4 low, 4 high); tick every 8 cycles; shadow_cnt sequence 1,2,3,1,2,3.
- div_val=0, start, run 10 cycles -> clk_div toggles every cycle; tick every 2 cycles; busy=1 throughout.
- div_val=1, start, stop after the 2nd tick (shadow_cnt=2) -> en_d=0 the next cycle; one further tick with shadow_cnt->0; done pulses exactly once when clk_div falls; then busy=0 and clk_div=0.
- stop issued exactly on a tick where shadow_cnt becomes 3 (C2_MAX) -> the drain tick wraps shadow_cnt to 1; done follows at the next falling toggle.
- Ignored inputs: load with div_val=5 during RUN, and start during DRAIN -> div_q unchanged and no restart. After done, a new start uses the old div_q.
